rojo_port_responder: RTL and testbench

Synthesizable multi-channel I/O peripheral model that sits on the RojoBlaze port bus: port_id, read_strobe, write_strobe, out_port, in_port, interrupt and interrupt_ack.
- Testbench pushes stimulus bytes into per-channel RX FIFOs; the core reads them with INPUT.
- Core OUTPUT writes are captured, tagged with channel, into one capture FIFO drained by the testbench.
- An interrupt FSM raises interrupt while RX data is pending and completes the ack handshake.

---
 rtl/kcpsmx3_inc.sv | 23 ++
 rtl/rojo_sync_fifo.sv | 46 ++++
 rtl/rojo_port_responder.sv | 171 +++++++++++++++++
 tb/tb_rojo_port_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx3_inc.sv
// Shared RojoBlaze port-bus definitions: bus widths, interrupt FSM states,
// address offsets above the channel window and error register bit positions.
package kcpsmx3_inc;

  localparam int PORT_WIDTH = 8;
  localparam int PORT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SERVICE
  } irq_state_t;

  // Offsets added to NUM_CH to form the status and error port IDs
  localparam int STATUS_OFS = 0;
  localparam int ERROR_OFS  = 1;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_CAP_OVF   = 1;
  localparam int ERR_STIM_DROP = 2;
  localparam int ERR_BITS      = 3;

endpackage

// File: rtl/rojo_sync_fifo.sv
// Synchronous FIFO with async active-high reset. Pointers carry one extra
// wrap bit so full/empty are distinguished by the MSB compare.
module rojo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  // A push into a full FIFO is legal when the head leaves on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rojo_port_responder.sv
// Multi-channel RojoBlaze port-bus peripheral: RX stimulus FIFOs, capture FIFO
// and interrupt handshake. Define ROJO_PORT_TIMESTAMP_EN to timestamp captures.
module rojo_port_responder #(
  parameter int PORT_WIDTH = kcpsmx3_inc::PORT_WIDTH,
  parameter int PORT_DEPTH = kcpsmx3_inc::PORT_DEPTH,
  parameter int NUM_CH     = 4,
  parameter int RX_DEPTH   = 8,
  parameter int CAP_DEPTH  = 16,
  parameter logic [PORT_WIDTH-1:0] EMPTY_VAL = '1,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORT_DEPTH-1:0] port_id,
  input  logic                  read_strobe,
  input  logic                  write_strobe,
  input  logic [PORT_WIDTH-1:0] out_port,
  output logic [PORT_WIDTH-1:0] in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  input  logic                  irq_en,
  input  logic                  stim_valid,
  input  logic [CHW-1:0]        stim_ch,
  input  logic [PORT_WIDTH-1:0] stim_data,
  output logic                  stim_ready,
  output logic                  cap_valid,
  input  logic                  cap_ready,
  output logic [CHW-1:0]        cap_ch,
  output logic [PORT_WIDTH-1:0] cap_data,
  output logic [15:0]           cap_time
);

  import kcpsmx3_inc::*;

  localparam logic [PORT_DEPTH-1:0] CH_LIMIT  = PORT_DEPTH'(NUM_CH);
  localparam logic [PORT_DEPTH-1:0] STATUS_ID = PORT_DEPTH'(NUM_CH + STATUS_OFS);
  localparam logic [PORT_DEPTH-1:0] ERROR_ID  = PORT_DEPTH'(NUM_CH + ERROR_OFS);
`ifdef ROJO_PORT_TIMESTAMP_EN
  localparam int CAP_W = 16 + CHW + PORT_WIDTH;
`else
  localparam int CAP_W = CHW + PORT_WIDTH;
`endif

  logic [PORT_WIDTH-1:0] rx_head [NUM_CH];
  logic [NUM_CH-1:0]     rx_full, rx_empty, rx_pop, rx_push;
  logic [PORT_WIDTH-1:0] status_word;
  logic [ERR_BITS-1:0]   err, err_evt;
  logic                  underflow, sel_full, sel_pop, stim_drop, err_clr;
  logic                  cap_wr, cap_pop, cap_push, cap_full, cap_empty, cap_ovf;
  logic [CAP_W-1:0]      cap_in, cap_head;
  irq_state_t            state;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
    rojo_sync_fifo #(.WIDTH(PORT_WIDTH), .DEPTH(RX_DEPTH)) u_rx (
      .clk(clk), .reset(reset), .push(rx_push[g]), .push_data(stim_data),
      .pop(rx_pop[g]), .full(rx_full[g]), .empty(rx_empty[g]), .head(rx_head[g])
    );
  end

  // Read decode: in_port mux, RX pops, underflow and stimulus channel select
  always_comb begin
    in_port     = EMPTY_VAL;
    rx_pop      = '0;
    underflow   = 1'b0;
    sel_full    = 1'b1;
    sel_pop     = 1'b0;
    status_word = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      status_word[n] = !rx_empty[n];
      if (port_id == PORT_DEPTH'(n)) begin
        in_port = rx_empty[n] ? EMPTY_VAL : rx_head[n];
        if (read_strobe) begin
          if (rx_empty[n]) underflow = 1'b1;
          else             rx_pop[n] = 1'b1;
        end
      end
      if (stim_ch == CHW'(n)) begin
        sel_full = rx_full[n];
        sel_pop  = rx_pop[n];
      end
    end
    if (port_id == STATUS_ID)     in_port = status_word;
    else if (port_id == ERROR_ID) in_port = PORT_WIDTH'(err);
  end

  always_comb begin
    rx_push = '0;
    for (int n = 0; n < NUM_CH; n++)
      rx_push[n] = stim_valid && (stim_ch == CHW'(n)) && (!rx_full[n] || rx_pop[n]);
  end

  assign stim_ready = !sel_full;
  assign stim_drop  = stim_valid && sel_full && !sel_pop;

  assign cap_wr    = write_strobe && (port_id < CH_LIMIT);
  assign cap_pop   = cap_valid && cap_ready;
  assign cap_push  = cap_wr && (!cap_full || cap_pop);
  assign cap_ovf   = cap_wr && cap_full && !cap_pop;
  assign cap_valid = !cap_empty;

`ifdef ROJO_PORT_TIMESTAMP_EN
  logic [15:0] ts_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_count <= '0;
    else       ts_count <= ts_count + 16'd1;
  end

  assign cap_in   = {ts_count, port_id[CHW-1:0], out_port};
  assign cap_time = cap_valid ? cap_head[CAP_W-1 -: 16] : 16'd0;
`else
  assign cap_in   = {port_id[CHW-1:0], out_port};
  assign cap_time = 16'd0;
`endif

  assign cap_data = cap_valid ? cap_head[PORT_WIDTH-1:0] : '0;
  assign cap_ch   = cap_valid ? cap_head[PORT_WIDTH +: CHW] : '0;

  rojo_sync_fifo #(.WIDTH(CAP_W), .DEPTH(CAP_DEPTH)) u_cap (
    .clk(clk), .reset(reset), .push(cap_push), .push_data(cap_in),
    .pop(cap_pop), .full(cap_full), .empty(cap_empty), .head(cap_head)
  );

  // A fresh error event outranks the read-clear on the same edge
  assign err_clr = read_strobe && (port_id == ERROR_ID);
  always_comb begin
    err_evt                = '0;
    err_evt[ERR_UNDERFLOW] = underflow;
    err_evt[ERR_CAP_OVF]   = cap_ovf;
    err_evt[ERR_STIM_DROP] = stim_drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else       err <= (err & ~{ERR_BITS{err_clr}}) | err_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (irq_en && !(&rx_empty)) begin
            state     <= PEND;
            interrupt <= 1'b1;
          end
        end
        PEND: begin
          if (!irq_en) begin
            state     <= IDLE;
            interrupt <= 1'b0;
          end else if (interrupt_ack) begin
            state     <= SERVICE;
            interrupt <= 1'b0;
          end
        end
        SERVICE: begin
          interrupt <= 1'b0;
          if (read_strobe && (port_id == STATUS_ID)) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rojo_port_responder.sv
// Self-checking bench for rojo_port_responder with a queue-based reference model.
// Honours ROJO_PORT_TIMESTAMP_EN for the expected capture timestamps.
module tb_rojo_port_responder;

  localparam int PW = 8;
  localparam int PD = 8;
  localparam int NCH = 4;
  localparam int RXD = 8;
  localparam int CAPD = 16;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  data;
    logic [15:0] ts;
  } cap_entry_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PD-1:0] port_id = '0;
  logic          read_strobe = 1'b0;
  logic          write_strobe = 1'b0;
  logic [PW-1:0] out_port = '0;
  logic [PW-1:0] in_port;
  logic          interrupt;
  logic          interrupt_ack = 1'b0;
  logic          irq_en = 1'b0;
  logic          stim_valid = 1'b0;
  logic [1:0]    stim_ch = '0;
  logic [PW-1:0] stim_data = '0;
  logic          stim_ready;
  logic          cap_valid;
  logic          cap_ready = 1'b0;
  logic [1:0]    cap_ch;
  logic [PW-1:0] cap_data;
  logic [15:0]   cap_time;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rxq [NCH][$];
  cap_entry_t  capq[$];
  logic [2:0]  merr;
  logic [15:0] mcyc;

  rojo_port_responder #(
    .PORT_WIDTH(PW), .PORT_DEPTH(PD), .NUM_CH(NCH), .RX_DEPTH(RXD),
    .CAP_DEPTH(CAPD), .EMPTY_VAL(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .irq_en(irq_en),
    .stim_valid(stim_valid), .stim_ch(stim_ch), .stim_data(stim_data),
    .stim_ready(stim_ready), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_ch(cap_ch), .cap_data(cap_data), .cap_time(cap_time)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) rxq[c].delete();
    capq.delete();
    merr = 3'b000;
    mcyc = 16'd0;
  endtask

  // Applies one clock edge worth of bus rules to the reference queues
  task automatic model_edge();
    logic [2:0] ev;
    cap_entry_t e;
    ev = 3'b000;
    if (read_strobe && port_id < NCH) begin
      if (rxq[port_id].size() > 0) void'(rxq[port_id].pop_front());
      else ev[0] = 1'b1;
    end
    if (stim_valid) begin
      if (rxq[stim_ch].size() < RXD) rxq[stim_ch].push_back(stim_data);
      else ev[2] = 1'b1;
    end
    if (cap_ready && capq.size() > 0) void'(capq.pop_front());
    if (write_strobe && port_id < NCH) begin
      if (capq.size() < CAPD) begin
        e.ch = port_id[1:0];
        e.data = out_port;
        e.ts = mcyc;
        capq.push_back(e);
      end else ev[1] = 1'b1;
    end
    if (read_strobe && port_id == NCH + 1) merr = 3'b000;
    merr = merr | ev;
    mcyc = mcyc + 16'd1;
  endtask

  function automatic logic [7:0] exp_in_port();
    logic [7:0] s;
    if (port_id < NCH) return (rxq[port_id].size() > 0) ? rxq[port_id][0] : 8'hFF;
    if (port_id == NCH) begin
      s = 8'h00;
      for (int c = 0; c < NCH; c++) s[c] = (rxq[c].size() > 0);
      return s;
    end
    if (port_id == NCH + 1) return {5'b00000, merr};
    return 8'hFF;
  endfunction

  function automatic logic [15:0] exp_cap_time();
`ifdef ROJO_PORT_TIMESTAMP_EN
    return (capq.size() > 0) ? capq[0].ts : 16'd0;
`else
    return 16'd0;
`endif
  endfunction

  task automatic idle_inputs();
    read_strobe = 1'b0;
    write_strobe = 1'b0;
    stim_valid = 1'b0;
    cap_ready = 1'b0;
    interrupt_ack = 1'b0;
    port_id = '0;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    irq_en = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_port !== 8'hFF) begin failures++; $display("[TB] FAIL reset_in_port: got %h expected ff", in_port); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL reset_interrupt: got %b expected 0", interrupt); end
    checks++; if (stim_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_stim_ready: got %b expected 1", stim_ready); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cap_valid: got %b expected 0", cap_valid); end
    checks++; if ({cap_ch, cap_data, cap_time} !== 26'd0) begin failures++; $display("[TB] FAIL reset_cap_head: got ch %h data %h time %h expected zeros", cap_ch, cap_data, cap_time); end
  endtask

  task automatic test_interrupt();
    int waited;
    irq_en = 1'b1;
    stim_valid = 1'b1; stim_ch = 2'd2; stim_data = 8'h3C;
    half();
    finish_cycle();
    stim_valid = 1'b0;
    waited = 0;
    half();
    while (interrupt !== 1'b1 && waited < 3) begin
      finish_cycle(); half(); waited++;
    end
    checks++; if (interrupt !== 1'b1 || waited > 1) begin failures++; $display("[TB] FAIL irq_assert: got %b after %0d cycles expected 1 within 2", interrupt, waited + 1); end
    finish_cycle();
    interrupt_ack = 1'b1;
    half(); finish_cycle();
    interrupt_ack = 1'b0;
    half();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL irq_ack_clear: got %b expected 0", interrupt); end
    finish_cycle();
    read_strobe = 1'b1; port_id = NCH;
    half();
    checks++; if (in_port !== 8'h04) begin failures++; $display("[TB] FAIL status_read: got %h expected 04", in_port); end
    finish_cycle();
    read_strobe = 1'b0;
    half();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL irq_idle_gap: got %b expected 0", interrupt); end
    finish_cycle();
    half();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("[TB] FAIL irq_rearm: got %b expected 1", interrupt); end
    irq_en = 1'b0;
    finish_cycle();
    half();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL irq_disable: got %b expected 0", interrupt); end
    finish_cycle();
  endtask

  task automatic test_read_pop();
    logic [7:0] req [4];
    logic [7:0] ids [4];
    ids = '{8'd2, 8'd2, 8'd5, 8'd5};
    req = '{8'h3C, 8'hFF, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) begin
      read_strobe = 1'b1; port_id = ids[i];
      half();
      checks++; if (in_port !== req[i] || in_port !== exp_in_port()) begin failures++; $display("[TB] FAIL read_pop_%0d: got %h expected %h", i, in_port, req[i]); end
      finish_cycle();
    end
    read_strobe = 1'b0;
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 9; i++) begin
      stim_valid = 1'b1; stim_ch = 2'd0; stim_data = 8'(i + 1);
      half();
      checks++; if (stim_ready !== (i < 8)) begin failures++; $display("[TB] FAIL rx_full_ready_%0d: got %b expected %b", i, stim_ready, (i < 8)); end
      finish_cycle();
    end
    stim_valid = 1'b0;
    read_strobe = 1'b1; port_id = NCH + 1;
    half();
    checks++; if (in_port !== 8'h04) begin failures++; $display("[TB] FAIL rx_drop_err: got %h expected 04", in_port); end
    finish_cycle();
    port_id = 8'd0;
    for (int i = 0; i < 8; i++) begin
      half();
      checks++; if (in_port !== 8'(i + 1)) begin failures++; $display("[TB] FAIL rx_order_%0d: got %h expected %h", i, in_port, 8'(i + 1)); end
      finish_cycle();
    end
    read_strobe = 1'b0;
  endtask

  task automatic test_capture();
    cap_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_strobe = 1'b1; port_id = 8'd1; out_port = 8'(i);
      half(); finish_cycle();
    end
    write_strobe = 1'b0;
    half();
    checks++; if (cap_valid !== 1'b1) begin failures++; $display("[TB] FAIL cap_fill_valid: got %b expected 1", cap_valid); end
    finish_cycle();
    read_strobe = 1'b1; port_id = NCH + 1;
    half();
    checks++; if (in_port !== 8'h02) begin failures++; $display("[TB] FAIL cap_ovf_err: got %h expected 02", in_port); end
    finish_cycle();
    read_strobe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap_ready = 1'b1;
      half();
      checks++; if (cap_valid !== 1'b1 || cap_ch !== 2'd1 || cap_data !== 8'(i)) begin failures++; $display("[TB] FAIL cap_drain_%0d: got valid %b ch %0d data %h expected 1 1 %h", i, cap_valid, cap_ch, cap_data, 8'(i)); end
      checks++; if (cap_time !== exp_cap_time()) begin failures++; $display("[TB] FAIL cap_drain_time_%0d: got %0d expected %0d", i, cap_time, exp_cap_time()); end
      finish_cycle();
    end
    cap_ready = 1'b0;
    half();
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("[TB] FAIL cap_empty: got %b expected 0", cap_valid); end
    finish_cycle();
  endtask

  task automatic test_timestamp();
    logic [15:0] t0, t1;
`ifdef ROJO_PORT_TIMESTAMP_EN
    t0 = 16'd10; t1 = 16'd13;
`else
    t0 = 16'd0; t1 = 16'd0;
`endif
    do_reset();
    for (int i = 0; i < 14; i++) begin
      write_strobe = (i == 10 || i == 13);
      port_id = 8'd3; out_port = 8'hA0 + 8'(i);
      half(); finish_cycle();
    end
    write_strobe = 1'b0;
    cap_ready = 1'b1;
    half();
    checks++; if (cap_time !== t0 || cap_data !== 8'hAA) begin failures++; $display("[TB] FAIL ts_first: got time %0d data %h expected %0d aa", cap_time, cap_data, t0); end
    finish_cycle();
    half();
    checks++; if (cap_time !== t1 || cap_data !== 8'hAD) begin failures++; $display("[TB] FAIL ts_second: got time %0d data %h expected %0d ad", cap_time, cap_data, t1); end
    finish_cycle();
    cap_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    irq_en = 1'b1;
    stim_valid = 1'b1; stim_ch = 2'd1; stim_data = 8'h5A;
    write_strobe = 1'b1; port_id = 8'd3; out_port = 8'h77;
    half(); finish_cycle();
    stim_ch = 2'd3; out_port = 8'h78;
    half(); finish_cycle();
    stim_valid = 1'b0; write_strobe = 1'b0;
    w = 0;
    half();
    while (interrupt !== 1'b1 && w < 4) begin
      finish_cycle(); half(); w++;
    end
    checks++; if (interrupt !== 1'b1 || cap_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_preload: got irq %b cap_valid %b expected 1 1", interrupt, cap_valid); end
    reset = 1'b1;
    model_reset();
    port_id = NCH;
    #1;
    checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_irq: got %b expected 0", interrupt); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_cap: got %b expected 0", cap_valid); end
    checks++; if (in_port !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_status: got %h expected 00", in_port); end
    irq_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int busy;
      busy = (i / 100) % 2;
      stim_valid   = ($urandom_range(0, 3) < (busy ? 3 : 1));
      stim_ch      = 2'($urandom_range(0, 3));
      stim_data    = 8'($urandom);
      read_strobe  = ($urandom_range(0, 2) == 0);
      write_strobe = ($urandom_range(0, 3) < (busy ? 3 : 1));
      port_id      = 8'($urandom_range(0, 7));
      out_port     = 8'($urandom);
      cap_ready    = ($urandom_range(0, 3) < (busy ? 1 : 3));
      half();
      checks++; if (in_port !== exp_in_port()) begin failures++; $display("[TB] FAIL rand_in_port cycle %0d id %0d: got %h expected %h", i, port_id, in_port, exp_in_port()); end
      checks++; if (stim_ready !== (rxq[stim_ch].size() < RXD)) begin failures++; $display("[TB] FAIL rand_stim_ready cycle %0d: got %b expected %b", i, stim_ready, (rxq[stim_ch].size() < RXD)); end
      checks++; if (cap_valid !== (capq.size() > 0)) begin failures++; $display("[TB] FAIL rand_cap_valid cycle %0d: got %b expected %b", i, cap_valid, (capq.size() > 0)); end
      if (capq.size() > 0) begin
        checks++; if (cap_ch !== capq[0].ch || cap_data !== capq[0].data) begin failures++; $display("[TB] FAIL rand_cap_head cycle %0d: got %0d/%h expected %0d/%h", i, cap_ch, cap_data, capq[0].ch, capq[0].data); end
      end
      checks++; if (cap_time !== exp_cap_time()) begin failures++; $display("[TB] FAIL rand_cap_time cycle %0d: got %0d expected %0d", i, cap_time, exp_cap_time()); end
      checks++; if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL rand_interrupt cycle %0d: got %b expected 0", i, interrupt); end
      finish_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] starting rojo_port_responder bench");
    test_reset();
    test_interrupt();
    test_read_pop();
    test_rx_full();
    test_capture();
    test_timestamp();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
